// File: rtl/mux_serializer_pkg.sv
// Shared types and constants for the mux_serializer slice.
// The PARITY state is always encoded so the state type is identical whether
// or not MUX_SER_PARITY_EN is defined.
package mux_ser_pkg;

  localparam int MAX_BITS = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } ser_state_t;

  // Select width needed to address n mux inputs (n is 2, 4 or 8).
  function automatic int sel_width(input int n);
    if (n <= 2) begin
      return 1;
    end else if (n <= 4) begin
      return 2;
    end else begin
      return 3;
    end
  endfunction

endpackage

// File: rtl/mux_serializer_if.sv
// Bundle of the word handshake, the mux tree connection and the serial
// handshake. The slave modport is the serializer, the master modport is the
// surrounding logic (upstream source, mux tree, downstream sink).
interface mux_serializer_if #(
  parameter int N_BITS = 8
) ();
  import mux_ser_pkg::*;

  localparam int SEL_W = sel_width(N_BITS);

  logic              in_valid;
  logic              in_ready;
  logic [N_BITS-1:0] in_data;
  logic [N_BITS-1:0] mux_in;
  logic [SEL_W-1:0]  mux_sel;
  logic              mux_out;
  logic              ser_valid;
  logic              ser_data;
  logic              ser_last;
  logic              ser_ready;

  modport slave (
    input  in_valid, in_data, mux_out, ser_ready,
    output in_ready, mux_in, mux_sel, ser_valid, ser_data, ser_last
  );

  modport master (
    output in_valid, in_data, mux_out, ser_ready,
    input  in_ready, mux_in, mux_sel, ser_valid, ser_data, ser_last
  );

endinterface

// File: rtl/mux_serializer_sel_counter.sv
// Select counter for the mux tree: clear has priority over enable, and the
// terminal-count flag marks the last data input of the tree.
module sel_counter
  import mux_ser_pkg::*;
#(
  parameter int N_BITS = 8,
  parameter int SEL_W  = $clog2(N_BITS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  output logic [SEL_W-1:0] count,
  output logic             tc
);

  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(N_BITS - 1);
  localparam logic [SEL_W-1:0] ONE_SEL  = SEL_W'(1);

  logic [SEL_W-1:0] count_r;

  // Select register: cleared on word start/end, advanced once per beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (enable) begin
      count_r <= count_r + ONE_SEL;
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;
  assign tc    = (count_r == LAST_SEL);

endmodule

// File: rtl/mux_serializer.sv
// Parallel-to-serial stage around an external N_BITS:1 mux tree.
// Registers an accepted word onto the tree data inputs, steps the tree select
// from 0 to N_BITS-1 and forwards the tree output as a serial stream with
// valid/ready/last. Bit 0 is sent first.
// Optional feature: define MUX_SER_PARITY_EN to append an even-parity beat
// after the data beats of every word.
module mux_serializer
  import mux_ser_pkg::*;
#(
  parameter int N_BITS = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  mux_serializer_if.slave bus
);

  localparam int SEL_W = $clog2(N_BITS);

  ser_state_t        state;
  logic              in_ready_r;
  logic              ser_valid_r;
  logic [N_BITS-1:0] word_r;
`ifdef MUX_SER_PARITY_EN
  logic              parity_r;
`endif

  logic              accept_s;
  logic              beat_s;
  logic              tc_s;
  logic              clear_s;
  logic              enable_s;
  logic              last_s;
  logic              data_s;
  logic [SEL_W-1:0]  sel_s;

  assign accept_s = bus.in_valid & in_ready_r;
  assign beat_s   = ser_valid_r & bus.ser_ready;

  // Counter control and serial data/last selection for the current state.
  always_comb begin
    clear_s  = 1'b0;
    enable_s = 1'b0;
    last_s   = 1'b0;
    data_s   = 1'b0;
`ifdef MUX_SER_PARITY_EN
    if (state == PARITY) begin
      clear_s  = beat_s;
      enable_s = 1'b0;
      last_s   = ser_valid_r;
      data_s   = ser_valid_r & parity_r;
    end else begin
      clear_s  = accept_s;
      enable_s = beat_s & ~tc_s;
      last_s   = 1'b0;
      data_s   = ser_valid_r & bus.mux_out;
    end
`else
    clear_s  = accept_s | (beat_s & tc_s);
    enable_s = beat_s & ~tc_s;
    last_s   = ser_valid_r & tc_s;
    data_s   = ser_valid_r & bus.mux_out;
`endif
  end

  // Word-level FSM with registered handshake outputs and the held word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      word_r      <= '0;
      in_ready_r  <= 1'b1;
      ser_valid_r <= 1'b0;
`ifdef MUX_SER_PARITY_EN
      parity_r    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept_s) begin
            state       <= SHIFT;
            word_r      <= bus.in_data;
            in_ready_r  <= 1'b0;
            ser_valid_r <= 1'b1;
`ifdef MUX_SER_PARITY_EN
            parity_r    <= ^bus.in_data;
`endif
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          if (beat_s && tc_s) begin
`ifdef MUX_SER_PARITY_EN
            state       <= PARITY;
`else
            state       <= IDLE;
            in_ready_r  <= 1'b1;
            ser_valid_r <= 1'b0;
`endif
          end else begin
            state <= SHIFT;
          end
        end
        PARITY: begin
`ifdef MUX_SER_PARITY_EN
          if (beat_s) begin
            state       <= IDLE;
            in_ready_r  <= 1'b1;
            ser_valid_r <= 1'b0;
          end else begin
            state <= PARITY;
          end
`else
          // Unreachable without the parity beat; recover to idle.
          state       <= IDLE;
          in_ready_r  <= 1'b1;
          ser_valid_r <= 1'b0;
`endif
        end
        default: begin
          state       <= IDLE;
          in_ready_r  <= 1'b1;
          ser_valid_r <= 1'b0;
        end
      endcase
    end
  end

  sel_counter #(
    .N_BITS (N_BITS),
    .SEL_W  (SEL_W)
  ) u_sel_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (clear_s),
    .enable (enable_s),
    .count  (sel_s),
    .tc     (tc_s)
  );

  assign bus.in_ready  = in_ready_r;
  assign bus.ser_valid = ser_valid_r;
  assign bus.ser_last  = last_s;
  assign bus.ser_data  = data_s;
  assign bus.mux_in    = word_r;
  assign bus.mux_sel   = sel_s;

endmodule

// File: doc/mux_serializer.md
Name: mux_serializer

Overview:
- Parallel-to-serial stage wrapped around the 8:1 gate-level multiplexer tree.
- Accepts an N-bit word over a valid/ready handshake and registers it.
- Drives the registered word and an incrementing select onto the external mux tree, then returns the tree's output as a serial bit stream with its own valid/ready/last handshake.
- The mux tree stays a separate combinational instance. This block is both its select source and its output consumer.

Parameters:
- N_BITS, 8, word width and mux fan-in; legal values are 2, 4 or 8.
- SEL_W, $clog2(N_BITS), select width; derived, never overridden.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream word valid
- in_ready  output  1  block can accept a word
- in_data  input  N_BITS  word to serialize, bit 0 sent first
- mux_in  output  N_BITS  registered word to mux tree data inputs
- mux_sel  output  SEL_W  select to mux tree
- mux_out  input  1  mux tree output
- ser_valid  output  1  serial bit valid
- ser_data  output  1  serial bit
- ser_last  output  1  final beat of current word
- ser_ready  input  1  downstream accepts serial bit

Behaviour:
- Reset (async assert, sync release): state=IDLE; mux_in=0; mux_sel=0; in_ready=1; ser_valid=0; ser_last=0; ser_data=0 (ser_data is mux_out gated by ser_valid).
- IDLE:
  - in_ready=1, ser_valid=0.
  - On in_valid&&in_ready: mux_in<=in_data, mux_sel<=0, state<=SHIFT.
- SHIFT:
  - in_ready=0, ser_valid=1.
  - ser_data=mux_out (combinational through the tree, no added latency).
  - ser_last=(mux_sel==N_BITS-1).
  - On ser_valid&&ser_ready:
    - if ser_last: state<=IDLE, mux_sel<=0.
    - else: mux_sel<=mux_sel+1.
  - With ser_ready=0: hold mux_sel and ser_data stable, and keep ser_valid high (no retraction).
- Latency: first serial bit is valid the cycle after input acceptance. With ser_ready tied high a word takes N_BITS cycles plus 1 IDLE cycle, giving a throughput of one word per N_BITS+1 cycles.
- Boundaries:
  - in_valid during SHIFT is ignored (in_ready=0); upstream must hold it.
  - mux_sel never wraps past N_BITS-1.
  - in_valid and the final ser handshake in the same cycle: the word is not accepted that cycle; it is accepted on the following IDLE cycle.
  - rst_n low mid-word: the word is discarded immediately; outputs take reset values the same cycle.
- mux_in is held constant for the whole word; it changes only on acceptance.

Optional Feature:
- Macro: MUX_SER_PARITY_EN.
- Defined:
  - Even parity of in_data is registered at acceptance (^in_data).
  - Extra PARITY state follows SHIFT: after the handshake at mux_sel==N_BITS-1 go to PARITY instead of IDLE.
  - In PARITY: ser_valid=1, ser_data=parity register, ser_last=1, mux_sel held at N_BITS-1; handshake -> IDLE.
  - ser_last is 0 throughout SHIFT.
  - Word takes N_BITS+1 beats.
- Undefined: no PARITY state or parity register; behaviour exactly as above.

Decomposition:
- Package mux_ser_pkg holds:
  - state enum ser_state_t {IDLE, SHIFT, PARITY}; PARITY is encoded even when unused.
  - Localparam MAX_BITS=8.
  - Function sel_width(n).
- One natural sub-module, sel_counter: SEL_W-bit counter with clear, enable and terminal-count output; provides mux_sel and ser_last.
- The mux tree is instantiated alongside this block by the integrator, not inside it.

Test Plan:
- Reset mid-word: accept 8'hA5, assert rst_n low after 3 beats -> same cycle ser_valid=0, mux_sel=0, in_ready=1; next word 8'h3C then serializes from bit 0.
- Basic stream: N_BITS=8, ser_ready=1, send 8'hA5 -> ser_data 1,0,1,0,0,1,0,1 on consecutive cycles; ser_last only on 8th beat; in_ready=1 on the following cycle.
- Backpressure: send 8'h81, drop ser_ready for 3 cycles at beat 2 -> ser_valid stays 1, mux_sel stays 1, ser_data stays 0; stream resumes intact.
- Back-to-back with held in_valid: present 8'hFF then 8'h00 -> 8 ones, one IDLE gap cycle, 8 zeros; no word dropped or duplicated.
- Width variant: N_BITS=4, send 4'b0110 -> bits 0,1,1,0, SEL_W=2, ser_last on beat 4.
- MUX_SER_PARITY_EN defined: send 8'h07 -> 8 data beats with ser_last=0, then a 9th beat ser_data=1, ser_last=1; send 8'h03 -> 9th beat ser_data=0.
